wb8_bus_arbiter: RTL and testbench

Parametrised 8-bit Wishbone interconnect that joins two bus masters (CPU, DMA engine) to NSLAVES slave peripherals through a programmable address map. It replaces the hand-written casez decoder in board top levels. It adds round-robin master arbitration, a parametrised match/mask decode table with a default slave, and an optional bus-timeout watchdog. It sits between the cpu/DMA instances and the rom/ram/uart/spi/timer/etc. wb8 slaves.

---
 rtl/wb8_bus_arbiter.sv | 141 ++++++++++++++
 tb/tb_wb8_bus_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb8_bus_arbiter.sv
// Two-master, NSLAVES-slave 8-bit Wishbone interconnect with round-robin arbitration and mask/match decode.
// Define WB8_BUSTIMEOUT_EN to enable the bus-timeout watchdog (error after TIMEOUT unacked strobe cycles).
module wb8_bus_arbiter #(
  parameter int                     NSLAVES       = 8,
  parameter logic [NSLAVES*32-1:0]  ADR_MATCH     = '0,
  parameter logic [NSLAVES*32-1:0]  ADR_MASK      = '0,
  parameter int                     DEFAULT_SLAVE = 0,
  parameter int                     TIMEOUT       = 255
) (
  input  logic                  I_wb_clk,
  input  logic                  I_reset_n,
  input  logic                  I_m0_cyc,
  input  logic                  I_m0_stb,
  input  logic                  I_m0_we,
  input  logic [31:0]           I_m0_adr,
  input  logic [7:0]            I_m0_dat,
  output logic [7:0]            O_m0_dat,
  output logic                  O_m0_ack,
  output logic                  O_m0_stall,
  output logic                  O_m0_err,
  input  logic                  I_m1_cyc,
  input  logic                  I_m1_stb,
  input  logic                  I_m1_we,
  input  logic [31:0]           I_m1_adr,
  input  logic [7:0]            I_m1_dat,
  output logic [7:0]            O_m1_dat,
  output logic                  O_m1_ack,
  output logic                  O_m1_stall,
  output logic                  O_m1_err,
  output logic [31:0]           O_s_adr,
  output logic [7:0]            O_s_dat,
  output logic                  O_s_we,
  output logic [NSLAVES-1:0]    O_s_stb,
  input  logic [NSLAVES*8-1:0]  I_s_dat,
  input  logic [NSLAVES-1:0]    I_s_ack,
  input  logic [NSLAVES-1:0]    I_s_stall
);

  localparam int SW = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

  logic [1:0]    state, state_next;
  logic          last_grant;
  logic          owner0, owner1;
  logic          own_stb;
  logic [31:0]   own_adr;
  logic [SW-1:0] sel;
  logic [7:0]    sel_dat;
  logic          sel_ack, sel_stall;
  logic          timeout_hit;

  assign owner0  = (state == ST_OWN0);
  assign owner1  = (state == ST_OWN1);
  assign own_stb = (owner0 & I_m0_stb) | (owner1 & I_m1_stb);
  assign own_adr = owner1 ? I_m1_adr : I_m0_adr;

  // Both-requesting ties go to whichever master did not win last time.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (I_m0_cyc && I_m1_cyc) state_next = last_grant ? ST_OWN0 : ST_OWN1;
        else if (I_m0_cyc)        state_next = ST_OWN0;
        else if (I_m1_cyc)        state_next = ST_OWN1;
      end
      ST_OWN0: if (!I_m0_cyc) state_next = I_m1_cyc ? ST_OWN1 : ST_IDLE;
      ST_OWN1: if (!I_m1_cyc) state_next = I_m0_cyc ? ST_OWN0 : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge I_wb_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
    end else begin
      state <= state_next;
      if (state_next == ST_OWN0 && state != ST_OWN0) last_grant <= 1'b0;
      if (state_next == ST_OWN1 && state != ST_OWN1) last_grant <= 1'b1;
    end
  end

  // Scan downward so the lowest matching slave index is the one left in sel.
  always_comb begin
    sel = SW'(DEFAULT_SLAVE);
    for (int i = NSLAVES - 1; i >= 0; i--) begin
      if ((own_adr & ADR_MASK[i*32 +: 32]) == (ADR_MATCH[i*32 +: 32] & ADR_MASK[i*32 +: 32]))
        sel = SW'(i);
    end
  end

  always_comb begin
    sel_dat   = '0;
    sel_ack   = 1'b0;
    sel_stall = 1'b0;
    for (int i = 0; i < NSLAVES; i++) begin
      if (sel == SW'(i)) begin
        sel_dat   = I_s_dat[i*8 +: 8];
        sel_ack   = I_s_ack[i];
        sel_stall = I_s_stall[i];
      end
    end
  end

`ifdef WB8_BUSTIMEOUT_EN
  logic [15:0] tmo_cnt;

  assign timeout_hit = own_stb & ~sel_ack & (tmo_cnt == 16'(TIMEOUT - 1));

  always_ff @(posedge I_wb_clk or negedge I_reset_n) begin
    if (!I_reset_n)
      tmo_cnt <= '0;
    else if (!own_stb || sel_ack || timeout_hit || state_next != state)
      tmo_cnt <= '0;
    else
      tmo_cnt <= tmo_cnt + 16'd1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign O_s_adr = own_adr;
  assign O_s_dat = owner1 ? I_m1_dat : I_m0_dat;
  assign O_s_we  = owner1 ? I_m1_we  : I_m0_we;
  assign O_s_stb = (own_stb && !timeout_hit) ? (NSLAVES'(1) << sel) : '0;

  // A timeout completes the stuck strobe as an error beat with 0xFF data.
  assign O_m0_dat   = owner0 ? (timeout_hit ? 8'hFF : sel_dat) : 8'h00;
  assign O_m0_ack   = owner0 & (sel_ack | timeout_hit);
  assign O_m0_err   = owner0 & timeout_hit;
  assign O_m0_stall = owner0 ? (sel_stall & ~timeout_hit) : 1'b1;

  assign O_m1_dat   = owner1 ? (timeout_hit ? 8'hFF : sel_dat) : 8'h00;
  assign O_m1_ack   = owner1 & (sel_ack | timeout_hit);
  assign O_m1_err   = owner1 & timeout_hit;
  assign O_m1_stall = owner1 ? (sel_stall & ~timeout_hit) : 1'b1;

endmodule

// File: tb/tb_wb8_bus_arbiter.sv
// Directed bench for wb8_bus_arbiter: arbitration, decode, stall, timeout and async reset behaviour.
// Follows WB8_BUSTIMEOUT_EN so the timeout expectations match the build.
module tb_wb8_bus_arbiter;

  localparam int NS = 8;
  localparam logic [NS*32-1:0] MATCH = {32'h60000000, 32'h50000000, 32'h30000000, 32'h20000000,
                                        32'h10000000, 32'hFFFFF000, 32'h10000000, 32'h40000000};
  localparam logic [NS*32-1:0] MASK  = {32'hF0000000, 32'hF0000000, 32'hF0000000, 32'hF0000000,
                                        32'hFF000000, 32'hFFFFF800, 32'hF0000000, 32'hF0000000};

  logic          clk = 1'b0;
  logic          rstN;
  logic          m0Cyc, m0Stb, m0We, m1Cyc, m1Stb, m1We;
  logic [31:0]   m0Adr, m1Adr;
  logic [7:0]    m0DatW, m1DatW;
  logic [7:0]    m0DatR, m1DatR;
  logic          m0Ack, m0Stall, m0Err, m1Ack, m1Stall, m1Err;
  logic [31:0]   sAdr;
  logic [7:0]    sDatW;
  logic          sWe;
  logic [NS-1:0] sStb;
  logic [NS*8-1:0] sDat;
  logic [NS-1:0] sAck, sStall;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  wb8_bus_arbiter #(
    .NSLAVES(NS), .ADR_MATCH(MATCH), .ADR_MASK(MASK), .DEFAULT_SLAVE(7), .TIMEOUT(10)
  ) dut (
    .I_wb_clk(clk), .I_reset_n(rstN),
    .I_m0_cyc(m0Cyc), .I_m0_stb(m0Stb), .I_m0_we(m0We), .I_m0_adr(m0Adr), .I_m0_dat(m0DatW),
    .O_m0_dat(m0DatR), .O_m0_ack(m0Ack), .O_m0_stall(m0Stall), .O_m0_err(m0Err),
    .I_m1_cyc(m1Cyc), .I_m1_stb(m1Stb), .I_m1_we(m1We), .I_m1_adr(m1Adr), .I_m1_dat(m1DatW),
    .O_m1_dat(m1DatR), .O_m1_ack(m1Ack), .O_m1_stall(m1Stall), .O_m1_err(m1Err),
    .O_s_adr(sAdr), .O_s_dat(sDatW), .O_s_we(sWe), .O_s_stb(sStb),
    .I_s_dat(sDat), .I_s_ack(sAck), .I_s_stall(sStall)
  );

  // Drive one master's request signals.
  task automatic applyStimulus(input int m, input logic cyc, input logic stb, input logic we,
                               input logic [31:0] adr, input logic [7:0] dat);
    if (m == 0) begin
      m0Cyc = cyc; m0Stb = stb; m0We = we; m0Adr = adr; m0DatW = dat;
    end else begin
      m1Cyc = cyc; m1Stb = stb; m1We = we; m1Adr = adr; m1DatW = dat;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected)
      else begin
        failCount++;
        $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
  endtask

  // Advance to just after the next rising edge.
  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int errSeen;
    rstN = 1'b0;
    applyStimulus(0, 0, 0, 0, 32'h0, 8'h0);
    applyStimulus(1, 0, 0, 0, 32'h0, 8'h0);
    sDat   = {8'h57, 8'h56, 8'h55, 8'h54, 8'h53, 8'h5A, 8'h51, 8'h50};
    sAck   = 8'hFF;
    sStall = 8'h00;
    #2;
    checkOutput("reset_stb", 32'(sStb), 32'h0);
    checkOutput("reset_m0_stall", 32'(m0Stall), 32'h1);
    checkOutput("reset_m1_stall", 32'(m1Stall), 32'h1);
    checkOutput("reset_acks", {30'h0, m0Ack, m1Ack}, 32'h0);
    checkOutput("reset_errs", {30'h0, m0Err, m1Err}, 32'h0);
    checkOutput("reset_dats", {16'h0, m0DatR, m1DatR}, 32'h0);
    @(negedge clk);
    rstN = 1'b1;

    // Contention straight after reset: m0 wins, then hands over to m1.
    @(negedge clk);
    applyStimulus(0, 1, 1, 0, 32'h30000000, 8'h00);
    applyStimulus(1, 1, 1, 0, 32'h20000000, 8'h00);
    #1;
    checkOutput("arb_idle_m0_stall", 32'(m0Stall), 32'h1);
    stepClk();
    checkOutput("cont_m0_ack", 32'(m0Ack), 32'h1);
    checkOutput("cont_m1_stall", 32'(m1Stall), 32'h1);
    checkOutput("cont_m1_ack", 32'(m1Ack), 32'h0);
    checkOutput("cont_stb5", 32'(sStb), 32'h20);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 32'h0, 8'h00);
    stepClk();
    checkOutput("handover_stb4", 32'(sStb), 32'h10);
    checkOutput("handover_m1_ack", 32'(m1Ack), 32'h1);
    checkOutput("handover_m1_dat", 32'(m1DatR), 32'h54);
    checkOutput("handover_adr", sAdr, 32'h20000000);
    checkOutput("handover_m0_stall", 32'(m0Stall), 32'h1);
    @(negedge clk);
    applyStimulus(1, 0, 0, 0, 32'h0, 8'h00);
    stepClk();
    checkOutput("idle_stb", 32'(sStb), 32'h0);
    @(negedge clk);
    applyStimulus(0, 1, 1, 0, 32'h30000000, 8'h00);
    applyStimulus(1, 1, 1, 0, 32'h20000000, 8'h00);
    stepClk();
    checkOutput("rr2_m0_ack", 32'(m0Ack), 32'h1);
    checkOutput("rr2_m1_stall", 32'(m1Stall), 32'h1);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 32'h0, 8'h00);
    applyStimulus(1, 0, 0, 0, 32'h0, 8'h00);
    stepClk();

    // Single-master read of slave 2, then default and priority decode.
    @(negedge clk);
    applyStimulus(0, 1, 1, 0, 32'hFFFFF004, 8'h00);
    #1;
    checkOutput("single_pre_ack", 32'(m0Ack), 32'h0);
    checkOutput("single_pre_stall", 32'(m0Stall), 32'h1);
    stepClk();
    checkOutput("single_stb2", 32'(sStb), 32'h04);
    checkOutput("single_dat", 32'(m0DatR), 32'h5A);
    checkOutput("single_ack", 32'(m0Ack), 32'h1);
    checkOutput("single_adr", sAdr, 32'hFFFFF004);
    @(negedge clk);
    applyStimulus(0, 1, 1, 0, 32'h00001234, 8'h00);
    #1;
    checkOutput("default_stb7", 32'(sStb), 32'h80);
    checkOutput("default_dat", 32'(m0DatR), 32'h57);
    @(negedge clk);
    applyStimulus(0, 1, 1, 0, 32'h10000010, 8'h00);
    #1;
    checkOutput("priority_stb1", 32'(sStb), 32'h02);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 32'h0, 8'h00);
    stepClk();

    // Slave 4 stalls for three cycles before acking.
    @(negedge clk);
    sAck   = 8'h00;
    sStall = 8'h10;
    applyStimulus(0, 1, 1, 0, 32'h20000000, 8'h00);
    for (int i = 0; i < 3; i++) begin
      stepClk();
      checkOutput($sformatf("stall_m0_stall_%0d", i), 32'(m0Stall), 32'h1);
      checkOutput($sformatf("stall_m0_ack_%0d", i), 32'(m0Ack), 32'h0);
    end
    @(negedge clk);
    sStall = 8'h00;
    sAck   = 8'h10;
    #1;
    checkOutput("stall_release_stall", 32'(m0Stall), 32'h0);
    checkOutput("stall_release_ack", 32'(m0Ack), 32'h1);
    checkOutput("stall_release_dat", 32'(m0DatR), 32'h54);
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 32'h0, 8'h00);
    sAck = 8'hFF;
    stepClk();

    // Slave 7 never acks m1.
    @(negedge clk);
    sAck = 8'h00;
    applyStimulus(1, 1, 1, 0, 32'h00001234, 8'h00);
`ifdef WB8_BUSTIMEOUT_EN
    for (int i = 1; i <= 9; i++) stepClk();
    checkOutput("tmo_cycle9_err", 32'(m1Err), 32'h0);
    checkOutput("tmo_cycle9_stb", 32'(sStb), 32'h80);
    stepClk();
    checkOutput("tmo_err", 32'(m1Err), 32'h1);
    checkOutput("tmo_ack", 32'(m1Ack), 32'h1);
    checkOutput("tmo_dat", 32'(m1DatR), 32'hFF);
    checkOutput("tmo_stb_off", 32'(sStb), 32'h0);
    stepClk();
    checkOutput("tmo_next_err", 32'(m1Err), 32'h0);
    checkOutput("tmo_next_stb", 32'(sStb), 32'h80);
    for (int i = 12; i <= 20; i++) stepClk();
    checkOutput("tmo_second_err", 32'(m1Err), 32'h1);
`else
    errSeen = 0;
    for (int i = 0; i < 1000; i++) begin
      stepClk();
      if (m1Err !== 1'b0) errSeen++;
    end
    checkOutput("notmo_err_count", 32'(errSeen), 32'h0);
    checkOutput("notmo_m1_ack", 32'(m1Ack), 32'h0);
    checkOutput("notmo_stb", 32'(sStb), 32'h80);
`endif
    @(negedge clk);
    applyStimulus(1, 0, 0, 0, 32'h0, 8'h00);
    stepClk();

    // Reset asserted in the middle of a write to slave 5.
    @(negedge clk);
    applyStimulus(0, 1, 1, 1, 32'h30000000, 8'hAA);
    stepClk();
    checkOutput("wr_stb5", 32'(sStb), 32'h20);
    checkOutput("wr_we", 32'(sWe), 32'h1);
    checkOutput("wr_dat", 32'(sDatW), 32'hAA);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("rst_mid_stb", 32'(sStb), 32'h0);
    checkOutput("rst_mid_m0_stall", 32'(m0Stall), 32'h1);
    checkOutput("rst_mid_m1_stall", 32'(m1Stall), 32'h1);
    @(negedge clk);
    applyStimulus(1, 1, 1, 0, 32'h20000000, 8'h00);
    rstN = 1'b1;
    #1;
    checkOutput("post_rst_idle_stb", 32'(sStb), 32'h0);
    stepClk();
    checkOutput("post_rst_m0_wins", 32'(sStb), 32'h20);
    checkOutput("post_rst_m0_stall", 32'(m0Stall), 32'h0);
    checkOutput("post_rst_m1_stall", 32'(m1Stall), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
